// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encodings and default width for the serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - combinational single-bit full adder
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic carryin,
    output logic sum,
    output logic carryout
);

    assign sum      = a ^ b ^ carryin;
    assign carryout = (a & b) | (carryin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, one bit per cycle LSB first, valid/ready handshakes
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    sa_state_t state, next_state;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, carryout_q, overflow_q;
    logic             fa_sum, fa_co;
    logic             last_bit;

    assign last_bit = (idx_q == LAST_IDX);

    full_adder_bit u_fa (
        .a        (a_q[idx_q]),
        .b        (b_q[idx_q]),
        .carryin  (carry_q),
        .sum      (fa_sum),
        .carryout (fa_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Sum bits are overwritten in place, so the previous result stays visible until bit 0 of the next run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carryin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= fa_sum;
                    carry_q      <= fa_co;
                    if (last_bit) begin
                        carryout_q <= fa_co;
                        overflow_q <= carry_q ^ fa_co;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = sum_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed-vector and random self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_valid, start_ready;
    logic [7:0] a, b, sum;
    logic       carryin, result_valid, result_ready, carryout, overflow, busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[7];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .carryin      (carryin),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .carryout     (carryout),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the acceptance edge.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        a = ta; b = tb_v; carryin = tc; start_valid = 1'b1;
        check("start_ready_idle", {31'd0, start_ready}, 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); carryin = 1'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!result_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("valid_dropped", {31'd0, result_valid}, 32'd0);
        check("start_ready_back", {31'd0, start_ready}, 32'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                                 input logic tc, input logic [7:0] es, input logic eco, input logic eov);
        int lat;
        launch(ta, tb_v, tc);
        wait_done(lat);
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, "_carryout"}, {31'd0, carryout}, {31'd0, eco});
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eov});
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] hold_sum;
        logic [8:0] full;
        logic [7:0] ra, rb;
        logic       rc, rov;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

        reset_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        a = 8'h00; b = 8'h00; carryin = 1'b0;
        #1;
        check("rst_start_ready", {31'd0, start_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_carryout", {31'd0, carryout}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                          vecs[i].exp_sum, vecs[i].exp_co, vecs[i].exp_ov);

        // Backpressure: result held for five cycles without result_ready.
        launch(8'h12, 8'h34, 1'b0);
        wait_done(lat);
        check("bp_latency", lat, 32'd8);
        hold_sum = sum;
        check("bp_sum", {24'd0, sum}, 32'h46);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid_held", {31'd0, result_valid}, 32'd1);
            check("bp_sum_stable", {24'd0, sum}, {24'd0, hold_sum});
            check("bp_co_stable", {31'd0, carryout}, 32'd0);
        end
        release_result();

        // start_valid held with new operands during RUN/DONE must not be accepted.
        launch(8'h21, 8'h43, 1'b1);
        start_valid = 1'b1; a = 8'hF0; b = 8'hF0; carryin = 1'b1;
        check("busy_start_ready", {31'd0, start_ready}, 32'd0);
        wait_done(lat);
        check("sv_latency", lat, 32'd8);
        check("sv_sum", {24'd0, sum}, 32'h65);
        check("sv_carryout", {31'd0, carryout}, 32'd0);
        @(posedge clk); #1;
        check("sv_done_held", {31'd0, result_valid}, 32'd1);
        check("sv_sum_held", {24'd0, sum}, 32'h65);
        start_valid = 1'b0;
        release_result();
        check("sv_no_accept", {31'd0, busy}, 32'd0);

        // Reset mid-operation after bit 3 has been registered.
        launch(8'hAA, 8'h55, 1'b0);
        for (int k = 0; k < 4; k++) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_start_ready", {31'd0, start_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
        check("mid_rst_sum", {24'd0, sum}, 32'd0);
        check("mid_rst_carryout", {31'd0, carryout}, 32'd0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_and_check("post_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        for (int n = 0; n < 256; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            rov  = (ra[7] == rb[7]) && (full[7] != ra[7]);
            run_and_check("rand", ra, rb, rc, full[7:0], full[8], rov);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
